ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the attached keyboard or mouse, for example 0xFF reset or 0xF4 enable-reporting, over the shared ps2_clk/ps2_data open-drain lines.
- Runs in the pclk domain.
- Produces per-line pull-low enables; the top level converts these into the inout pad drive.
- Sits beside the PS/2 receive path. It owns the bus only while a transmission is in progress.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// States, frame bit positions and 65 MHz timing defaults.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      DATA,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   localparam int BIT_LAST_DATA = 8;
   localparam int BIT_PARITY    = 9;
   localparam int BIT_STOP      = 10;
   localparam int BIT_ACK       = 11;

   localparam int DEF_INHIBIT_CYCLES = 7800;
   localparam int DEF_TIMEOUT_CYCLES = 975000;
   localparam int DEF_FILTER_LEN     = 8;

   // {stop, odd parity, data}, shifted out LSB first
   function automatic logic [9:0] ps2_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer, FILTER_LEN glitch filter, fall pulse.
// Ports: pclk, rst (async active-low), line_in (raw pad), level (filtered), fall (1-cycle pulse on 1->0).
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic pclk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          fall_q;

   // Idle bus level is high, so reset the chain to 1 to avoid a false edge.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], line_in};
         fall_q <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
            fall_q  <= level_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over open-drain clk/data.
// Ports: pclk, rst (async active-low); tx_data/tx_valid/tx_ready request handshake;
// tx_done/tx_err result pulses; ps2_clk_in/ps2_data_in raw pads; ps2_clk_oe/ps2_data_oe pull-low enables.
// Optional PS2_HOST_TX_TIMEOUT_EN adds a watchdog on device clock edges.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);

   logic clk_lvl;
   logic clk_fall;
   logic data_lvl;
   logic data_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .pclk    (pclk),
      .rst     (rst),
      .line_in (ps2_clk_in),
      .level   (clk_lvl),
      .fall    (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .pclk    (pclk),
      .rst     (rst),
      .line_in (ps2_data_in),
      .level   (data_lvl),
      .fall    (data_fall_unused)
   );

   ps2_state_e    state_q, state_d;
   logic [IW-1:0] inh_q, inh_d;
   logic [3:0]    bit_q, bit_d;
   logic [9:0]    shift_q, shift_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

`ifdef PS2_HOST_TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wdog_q, wdog_d;
   logic          watched;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         inh_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         inh_q     <= inh_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

`ifdef PS2_HOST_TX_TIMEOUT_EN
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) wdog_q <= '0;
      else      wdog_q <= wdog_d;
   end
`endif

   always_comb begin
      state_d   = state_q;
      inh_d     = inh_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_valid) begin
               shift_d   = ps2_frame(tx_data);
               inh_d     = '0;
               bit_d     = '0;
               clk_oe_d  = 1'b1;
               // a one-cycle inhibit is also its final cycle
               data_oe_d = (INHIBIT_CYCLES == 1);
               state_d   = INHIBIT;
            end
         end

         INHIBIT: begin
            inh_d = inh_q + 1'b1;
            // request-to-send: data goes low in the last inhibit cycle
            if (inh_q == IW'(INHIBIT_CYCLES - 2)) begin
               data_oe_d = 1'b1;
            end
            if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               state_d   = START;
            end
         end

         START: begin
            if (clk_fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = {1'b1, shift_q[9:1]};
               bit_d     = 4'd1;
               state_d   = DATA;
            end
         end

         DATA: begin
            if (clk_fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = {1'b1, shift_q[9:1]};
               bit_d     = bit_q + 4'd1;
               if (bit_q == 4'(BIT_STOP - 1)) begin
                  state_d = ACK;
               end
            end
         end

         ACK: begin
            if (clk_fall) begin
               bit_d = 4'(BIT_ACK);
               if (!data_lvl) begin
                  state_d = WAIT_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         WAIT_IDLE: begin
            if (clk_lvl && data_lvl) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = IDLE;
         end
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      watched = (state_q == START) || (state_q == DATA) ||
                (state_q == ACK)   || (state_q == WAIT_IDLE);
      wdog_d  = '0;
      if (watched) begin
         if (clk_fall || (state_d != state_q)) wdog_d = '0;
         else                                  wdog_d = wdog_q + 1'b1;
         // a device edge in the same cycle wins over the timeout
         if (!clk_fall && (wdog_q == TW'(TIMEOUT_CYCLES - 1))) begin
            state_d   = IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
            wdog_d    = '0;
         end
      end
`endif
   end

   assign tx_ready    = (state_q == IDLE);
   assign tx_done     = done_q;
   assign tx_err      = err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device receive model.
// Directed byte vectors with hand-computed frames (start, data LSB first, odd parity, stop).
module tb_ps2_host_tx;

   localparam int INH  = 100;
   localparam int TO   = 5000;
   localparam int FL   = 4;
   localparam int HALF = 200;

   logic       pclk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_err;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       dev_clk;
   logic       dev_data;

   // open-drain wired-AND of host and device pulls
   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO),
      .FILTER_LEN     (FL)
   ) dut (
      .pclk        (pclk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int done_cnt  = 0;
   int err_cnt   = 0;
   int both_cnt  = 0;
   int err_cyc   = 0;
   int last_fall = 0;
   logic        ready_at_done = 1'b0;
   logic [10:0] fr;

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   always @(negedge pclk) begin
      if (tx_done) begin
         done_cnt      <= done_cnt + 1;
         ready_at_done <= tx_ready;
      end
      if (tx_err) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
      if (tx_done && tx_err) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Device side: time the inhibit, then clock out nfalls edges and sample the host data.
   task automatic device_rx(input int nfalls, input bit ack);
      int   n;
      int   len;
      int   hi;
      logic last;
      n = 0;
      while (ps2_clk_oe !== 1'b1 && n < 300) begin
         @(negedge pclk);
         n++;
      end
      chk("inh_start", ps2_clk_oe, 1);
      len  = 0;
      hi   = 0;
      last = 1'b0;
      while (ps2_clk_oe === 1'b1 && len < 1000) begin
         if (ps2_data_oe) hi++;
         last = ps2_data_oe;
         len++;
         @(negedge pclk);
      end
      chk("inh_len", len, INH);
      chk("inh_data_cnt", hi, 1);
      chk("inh_data_last", last, 1);
      fr    = '0;
      fr[0] = ps2_data_in;
      for (int k = 1; k <= nfalls; k++) begin
         if (k == 11 && ack) dev_data = 1'b0;
         repeat (HALF) @(negedge pclk);
         dev_clk   = 1'b0;
         last_fall = cyc;
         repeat (HALF) @(negedge pclk);
         if (k <= 10) fr[k] = ps2_data_in;
         dev_clk = 1'b1;
      end
      if (nfalls == 11) begin
         repeat (50) @(negedge pclk);
         dev_data = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit hold);
      @(negedge pclk);
      chk("ready_before", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge pclk);
      chk("busy_after", tx_ready, 0);
      if (hold) tx_data = 8'hAA;
      else      tx_valid = 1'b0;
   endtask

   task automatic full(input string tag, input logic [7:0] b, input bit ack,
                       input logic [10:0] exp_fr, input bit hold);
      int d0;
      int e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send(b, hold);
      if (hold) begin
         fork
            device_rx(11, 1'b1);
            begin
               repeat (3000) @(negedge pclk);
               chk({tag, "_hold_busy"}, tx_ready, 0);
               tx_valid = 1'b0;
            end
         join
      end else begin
         device_rx(11, ack);
      end
      repeat (20) @(negedge pclk);
      chk({tag, "_frame"}, fr, exp_fr);
      chk({tag, "_done"}, done_cnt - d0, ack ? 1 : 0);
      chk({tag, "_err"}, err_cnt - e0, ack ? 0 : 1);
      chk({tag, "_ready"}, tx_ready, 1);
      chk({tag, "_oe"}, {ps2_clk_oe, ps2_data_oe}, 0);
      if (ack) chk({tag, "_ready_at_done"}, ready_at_done, 1);
   endtask

   initial begin
      #(10 * 200000);
      $display("FAIL global_timeout got running exp finished");
      $fatal(1);
   end

   initial begin
      int e0;
      int n;
      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (3) @(negedge pclk);
      chk("rst_ready", tx_ready, 1);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_err", tx_err, 0);
      rst = 1'b1;
      repeat (5) @(negedge pclk);

      // 0xF4 has five ones, so odd parity bit is 0
      full("f4", 8'hF4, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0);
      full("x00", 8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0);
      full("xff", 8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0);
      // 0xED: six ones -> parity 1; device withholds ack
      full("noack", 8'hED, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0);
      // 0x5A: four ones -> parity 1; tx_valid held with 0xAA on the bus input
      full("hold", 8'h5A, 1'b1, {1'b1, 1'b1, 8'h5A, 1'b0}, 1'b1);
      repeat (300) @(negedge pclk);
      chk("hold_no_second", ps2_clk_oe, 0);

      // reset while bit 4 (0) of 0x0F is on the line
      send(8'h0F, 1'b0);
      device_rx(5, 1'b1);
      chk("rst_bits", fr[5:1], 5'h0F);
      repeat (50) @(negedge pclk);
      chk("pre_rst_data_oe", ps2_data_oe, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_clk_oe", ps2_clk_oe, 0);
      chk("mid_rst_data_oe", ps2_data_oe, 0);
      chk("mid_rst_ready", tx_ready, 1);
      repeat (5) @(negedge pclk);
      rst = 1'b1;
      repeat (5) @(negedge pclk);
      full("after_rst", 8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0);

      // device stops clocking after fall 5
      send(8'h12, 1'b0);
      device_rx(5, 1'b1);
      e0 = err_cnt;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      n = 0;
      while (err_cnt == e0 && n < 6000) begin
         @(negedge pclk);
         n++;
      end
      chk("to_seen", err_cnt - e0, 1);
      // raw pad edge to internal fall adds the conditioning latency
      chk("to_window", ((err_cyc - last_fall) >= TO) &&
                       ((err_cyc - last_fall) <= TO + 15), 1);
      repeat (5) @(negedge pclk);
      chk("to_ready", tx_ready, 1);
      chk("to_oe", {ps2_clk_oe, ps2_data_oe}, 0);
`else
      n = 0;
      repeat (6000) @(negedge pclk);
      chk("stay_busy", tx_ready, 0);
      chk("stay_no_err", err_cnt - e0 + n, 0);
      rst = 1'b0;
      repeat (5) @(negedge pclk);
      rst = 1'b1;
      repeat (5) @(negedge pclk);
`endif
      full("final", 8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0);
      chk("never_both", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
